mem_dp: RTL and testbench
=========================

# mem_dp

Parametrised successor of the single-port `mem` block: a simple dual-port memory with an independent write port and read port, configurable read latency and configurable same-address collision policy. It tracks a per-entry written bit so reads of never-written locations are flagged, and it keeps a saturating error counter. It sits between the stimulus/processor side and downstream consumers wherever the design needs concurrent read and write access to a small register-file-sized store.

## Interface

- `DATA_WIDTH`, 6: word width in bits.
- `ADDR_WIDTH`, 3: address width; depth is 2**ADDR_WIDTH (derived, not a parameter).
- `READ_LATENCY`, 1: read latency in cycles; legal values 1 or 2.
- `BYPASS`, 1: same-address read/write collision policy; 1 returns new data, 0 returns old data.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `RESET_L`  in  1  asynchronous, active-low reset.
- `write`  in  1  write enable.
- `wr_address`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `read`  in  1  read enable.
- `rd_address`  in  ADDR_WIDTH  read address.
- `clear`  in  1  synchronous clear of all written bits.
- `data_out`  out  DATA_WIDTH  read data.
- `valid_out`  out  1  one-cycle strobe: `data_out`/`err` carry a read result.
- `err`  out  1  qualifies `valid_out`: the read hit an unwritten entry.
- `err_count`  out  8  saturating count of `err` strobes.

## Operation

- Write: at an edge with `write`=1, `mem[wr_address]` <= `wr_data` and `written[wr_address]` <= 1.
- Read: at an edge with `read`=1, the block samples `rd_address`. The result comes out `READ_LATENCY` cycles later with `valid_out`=1.
  - Written entry: `data_out` = stored word, `err`=0.
  - Unwritten entry: `data_out` = 0, `err`=1.
- Idle: with no result due, `valid_out`=0 and `err`=0. `data_out` holds its last value.
- Collision (`read` and `write` at the same edge, `rd_address` == `wr_address`):
  - `BYPASS`=1: result is `wr_data` with `err`=0.
  - `BYPASS`=0: result is the pre-write contents, and `err` reflects the pre-write written bit.
  - Different addresses never interact.
- Clear: at an edge with `clear`=1, all written bits go to 0.
  - A write at the same edge sets its own written bit; write wins over clear.
  - A read at the same edge sees the pre-clear written bits, subject to the collision rule above.
  - Array data is not modified.
- `err_count` increments at each edge where `err` is driven to 1. It saturates at 255 and never wraps.
- Back-to-back reads are allowed every cycle. Throughput is one result per cycle at either latency.

## Timing

- Reset (`RESET_L`=0, asynchronous assert, released synchronously by the design upstream) immediately forces:
  - `data_out`=0, `valid_out`=0, `err`=0, `err_count`=0;
  - all written bits 0;
  - the read pipeline flushed.
- Array contents are not reset.
- A read in flight when reset asserts is discarded. No `valid_out` is produced for it after release.
- `READ_LATENCY`=1: read sampled at edge k; outputs update at edge k and are visible during cycle k..k+1.
- `READ_LATENCY`=2: outputs update at edge k+1.
- The written-bit check and collision decision are made at the sampling edge k. A write at edge k+1 does not change a read sampled at k, even with latency 2.
- Only `err_count` accumulates. `valid_out` and `err` are single-cycle per read.

## Test plan

- Reset, then read addr 3 with no prior write -> `valid_out`=1, `err`=1, `data_out`=0 after `READ_LATENCY` cycles; `err_count`=1.
- Write 0x2A to addr 5; read addr 5 next cycle -> `data_out`=0x2A, `err`=0. Repeat with `READ_LATENCY`=2 -> strobe one cycle later.
- Same-edge write 0x15 and read of addr 2, where addr 2 previously holds 0x07:
  - `BYPASS`=1 -> `data_out`=0x15, `err`=0.
  - `BYPASS`=0 -> `data_out`=0x07, `err`=0.
  - Repeat on never-written addr 2 with `BYPASS`=0 -> `err`=1.
- Fill all 8 entries; pulse `clear` together with a write of 0x3F to addr 1; then read addr 0 and addr 1 -> addr 0 `err`=1; addr 1 `data_out`=0x3F, `err`=0.
- 260 consecutive reads of an unwritten address -> `valid_out` high every cycle; `err_count` stops at 255.
- Issue a read, assert `RESET_L`=0 before its result is due -> outputs 0 immediately; no `valid_out` after release; `err_count`=0.

Source files
------------

// File: rtl/mem_dp.sv
// Simple dual-port memory with per-entry written bits, configurable read latency
// (1 or 2), same-address collision policy and a saturating error counter.
module mem_dp #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 3,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input  logic                  clk,
    input  logic                  RESET_L,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  err,
    output logic [7:0]            err_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      written_q, written_d;

    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_err;

    logic                  res_valid;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_err;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [7:0]            count_q, count_d;

    // Read result is resolved at the sampling edge from pre-write/pre-clear state.
    always_comb begin
        collide = write && (wr_address == rd_address);
        rd_word = '0;
        rd_err  = 1'b0;
        if (collide && (BYPASS != 0)) begin
            rd_word = wr_data;
        end else if (written_q[rd_address]) begin
            rd_word = mem_q[rd_address];
        end else begin
            rd_err = 1'b1;
        end
    end

    // A write at the same edge as clear keeps its own written bit.
    always_comb begin
        written_d = written_q;
        if (clear) begin
            written_d = '0;
        end
        if (write) begin
            written_d[wr_address] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    always_ff @(posedge clk) begin
        if (write) begin
            mem_q[wr_address] <= wr_data;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  pipe_valid_q;
            logic [DATA_WIDTH-1:0] pipe_data_q;
            logic                  pipe_err_q;

            always_ff @(posedge clk or negedge RESET_L) begin
                if (!RESET_L) begin
                    pipe_valid_q <= 1'b0;
                    pipe_data_q  <= '0;
                    pipe_err_q   <= 1'b0;
                end else begin
                    pipe_valid_q <= read;
                    pipe_data_q  <= rd_word;
                    pipe_err_q   <= rd_err;
                end
            end

            assign res_valid = pipe_valid_q;
            assign res_data  = pipe_data_q;
            assign res_err   = pipe_err_q;
        end else begin : g_lat1
            assign res_valid = read;
            assign res_data  = rd_word;
            assign res_err   = rd_err;
        end
    endgenerate

    // data_out holds its last result while idle; err is only ever a strobe.
    always_comb begin
        valid_d = res_valid;
        err_d   = res_valid & res_err;
        data_d  = res_valid ? res_data : data_q;
        count_d = count_q;
        if (err_d && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign err       = err_q;
    assign err_count = count_q;

endmodule

// File: tb/tb_mem_dp.sv
// Bench for mem_dp: four instances cover both latencies and both collision
// policies, checked against directed vectors and a cycle-level reference model.
module tb_mem_dp;

    logic       clk;
    logic       RESET_L;
    logic       write;
    logic [2:0] wr_address;
    logic [5:0] wr_data;
    logic       read;
    logic [2:0] rd_address;
    logic       clear;

    wire [5:0] dout [4];
    wire       vout [4];
    wire       eout [4];
    wire [7:0] ecnt [4];

    // instance g: latency g/2+1, BYPASS=1 for even g
    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_dp #(
            .DATA_WIDTH  (6),
            .ADDR_WIDTH  (3),
            .READ_LATENCY(g / 2 + 1),
            .BYPASS      (1 - (g % 2))
        ) u_dut (
            .clk       (clk),
            .RESET_L   (RESET_L),
            .write     (write),
            .wr_address(wr_address),
            .wr_data   (wr_data),
            .read      (read),
            .rd_address(rd_address),
            .clear     (clear),
            .data_out  (dout[g]),
            .valid_out (vout[g]),
            .err       (eout[g]),
            .err_count (ecnt[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [5:0] m_mem [8];
    logic [7:0] m_wr;
    int         cyc;
    logic       sv [4][4];
    logic [5:0] sd [4][4];
    logic       se [4][4];
    logic [5:0] last_d [4];
    int         m_cnt [4];
    logic       ev [4];
    logic       ee [4];
    logic [5:0] ed [4];

    typedef struct {
        logic       w;
        logic [2:0] wa;
        logic [5:0] wd;
        logic       r;
        logic [2:0] ra;
        logic       c;
        logic [5:0] d_b1;
        logic       e_b1;
        logic [5:0] d_b0;
        logic       e_b0;
    } vec_t;

    vec_t tbl[$];

    function automatic int lat_of(input int i);
        return i / 2 + 1;
    endfunction

    function automatic bit byp_of(input int i);
        return (i % 2) == 0;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = '0;
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 4; s++) begin
                sv[i][s] = 1'b0;
                sd[i][s] = '0;
                se[i][s] = 1'b0;
            end
            last_d[i] = '0;
            m_cnt[i]  = 0;
            ev[i]     = 1'b0;
            ee[i]     = 1'b0;
            ed[i]     = '0;
        end
    endtask

    // One rising edge: schedule the read result lat-1 edges ahead, then update storage.
    task automatic model_edge(input logic w, input logic [2:0] wa, input logic [5:0] wd,
                              input logic r, input logic [2:0] ra, input logic c);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                int s;
                s = (cyc + lat_of(i) - 1) % 4;
                sv[i][s] = 1'b1;
                if (w && (wa == ra) && byp_of(i)) begin
                    sd[i][s] = wd;
                    se[i][s] = 1'b0;
                end else if (m_wr[ra]) begin
                    sd[i][s] = m_mem[ra];
                    se[i][s] = 1'b0;
                end else begin
                    sd[i][s] = '0;
                    se[i][s] = 1'b1;
                end
            end
        end
        if (c) m_wr = '0;
        if (w) begin
            m_mem[wa] = wd;
            m_wr[wa]  = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            int s;
            s = cyc % 4;
            if (sv[i][s]) begin
                ev[i]     = 1'b1;
                ed[i]     = sd[i][s];
                ee[i]     = se[i][s];
                last_d[i] = sd[i][s];
                if (se[i][s] && m_cnt[i] < 255) m_cnt[i]++;
                sv[i][s] = 1'b0;
            end else begin
                ev[i] = 1'b0;
                ee[i] = 1'b0;
                ed[i] = last_d[i];
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("valid", i, 32'(vout[i]), 32'(ev[i]));
            chk("err", i, 32'(eout[i]), 32'(ee[i]));
            chk("data", i, 32'(dout[i]), 32'(ed[i]));
            chk("err_count", i, 32'(ecnt[i]), 32'(m_cnt[i]));
        end
    endtask

    task automatic step(input logic w, input logic [2:0] wa, input logic [5:0] wd,
                        input logic r, input logic [2:0] ra, input logic c);
        write      = w;
        wr_address = wa;
        wr_data    = wd;
        read       = r;
        rd_address = ra;
        clear      = c;
        @(posedge clk);
        model_edge(w, wa, wd, r, ra, c);
        #1;
        check_all();
        write = 1'b0;
        read  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic check_zero(input string nm);
        for (int i = 0; i < 4; i++) begin
            chk({nm, "_data"}, i, 32'(dout[i]), 32'd0);
            chk({nm, "_valid"}, i, 32'(vout[i]), 32'd0);
            chk({nm, "_err"}, i, 32'(eout[i]), 32'd0);
            chk({nm, "_count"}, i, 32'(ecnt[i]), 32'd0);
        end
    endtask

    task automatic add(input logic w, input logic [2:0] wa, input logic [5:0] wd,
                       input logic r, input logic [2:0] ra, input logic c,
                       input logic [5:0] d1, input logic e1, input logic [5:0] d0, input logic e0);
        vec_t v;
        v.w = w; v.wa = wa; v.wd = wd; v.r = r; v.ra = ra; v.c = c;
        v.d_b1 = d1; v.e_b1 = e1; v.d_b0 = d0; v.e_b0 = e0;
        tbl.push_back(v);
    endtask

    task automatic chk_row(input int i, input vec_t v);
        chk("tbl_valid", i, 32'(vout[i]), 32'd1);
        chk("tbl_data", i, 32'(dout[i]), byp_of(i) ? 32'(v.d_b1) : 32'(v.d_b0));
        chk("tbl_err", i, 32'(eout[i]), byp_of(i) ? 32'(v.e_b1) : 32'(v.e_b0));
    endtask

    initial begin
        RESET_L    = 1'b0;
        write      = 1'b0;
        wr_address = '0;
        wr_data    = '0;
        read       = 1'b0;
        rd_address = '0;
        clear      = 1'b0;
        cyc        = 0;
        model_reset();
        #3;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        RESET_L = 1'b1;

        //  w  wa    wd      r  ra    c     d_b1   e_b1  d_b0   e_b0
        add(0, 3'd0, 6'h00, 1, 3'd3, 0,    6'h00, 1,    6'h00, 1);
        add(1, 3'd5, 6'h2A, 0, 3'd0, 0,    6'h00, 0,    6'h00, 0);
        add(0, 3'd0, 6'h00, 1, 3'd5, 0,    6'h2A, 0,    6'h2A, 0);
        add(1, 3'd2, 6'h07, 0, 3'd0, 0,    6'h00, 0,    6'h00, 0);
        add(1, 3'd2, 6'h15, 1, 3'd2, 0,    6'h15, 0,    6'h07, 0);
        add(1, 3'd6, 6'h11, 1, 3'd6, 0,    6'h11, 0,    6'h00, 1);
        for (int a = 0; a < 8; a++) begin
            add(1, 3'(a), 6'(8'h30 + a), 0, 3'd0, 0, 6'h00, 0, 6'h00, 0);
        end
        add(1, 3'd1, 6'h3F, 1, 3'd2, 1,    6'h32, 0,    6'h32, 0);
        add(0, 3'd0, 6'h00, 1, 3'd0, 0,    6'h00, 1,    6'h00, 1);
        add(0, 3'd0, 6'h00, 1, 3'd1, 0,    6'h3F, 0,    6'h3F, 0);
        add(0, 3'd0, 6'h00, 1, 3'd2, 0,    6'h00, 1,    6'h00, 1);

        for (int t = 0; t < tbl.size(); t++) begin
            vec_t v;
            v = tbl[t];
            step(v.w, v.wa, v.wd, v.r, v.ra, v.c);
            if (v.r) begin
                chk_row(0, v);
                chk_row(1, v);
            end
            idle();
            if (v.r) begin
                chk_row(2, v);
                chk_row(3, v);
            end
            if (t == 0) begin
                for (int i = 0; i < 4; i++) chk("first_count", i, 32'(ecnt[i]), 32'd1);
            end
        end

        // Long run of unwritten reads: strobe every cycle, counter saturates.
        for (int n = 0; n < 260; n++) begin
            step(1'b0, 3'd0, 6'd0, 1'b1, 3'd0, 1'b0);
        end
        idle();
        for (int i = 0; i < 4; i++) chk("sat_count", i, 32'(ecnt[i]), 32'd255);

        // Randomised traffic, checked by the model every cycle.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 15) == 0));
        end

        // Reset with a read in flight.
        step(1'b1, 3'd4, 6'h1C, 1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 6'd0, 1'b1, 3'd4, 1'b0);
        #2;
        RESET_L = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        RESET_L = 1'b1;
        repeat (3) idle();
        for (int i = 0; i < 4; i++) chk("post_reset_count", i, 32'(ecnt[i]), 32'd0);

        // Storage survives reset but written bits do not.
        step(1'b0, 3'd0, 6'd0, 1'b1, 3'd4, 1'b0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
